// File: rtl/alu_a2_seq.sv
// alu_a2_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ADD/SUB/logic/shift ops and an iterative shift-add multiply.
// Only one operation is in flight at a time. The result and the flags stay
// in registers until the consumer takes them.
module alu_a2_seq #(
  parameter int bits   = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bits-1:0] RA,
  input  logic [bits-1:0] RB,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [bits-1:0] out,
  output logic [bits-1:0] out_hi,
  output logic            carry_out,
  output logic            overflow,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(bits);   // shift-amount and iteration-counter width

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [2*bits-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [bits-1:0]     mplier_q, mplier_d; // multiplier, consumed LSB first
  logic [2*bits-1:0]   acc_q, acc_d;       // partial product
  logic [SW-1:0]       cnt_q, cnt_d;
  logic [bits-1:0]     lo_q, lo_d, hi_q, hi_d;
  logic                c_q, c_d, v_q, v_d, z_q, z_d, ill_q, ill_d;

  // Single-cycle datapath signals, computed straight from the inputs.
  logic [bits:0]       sum_w, dif_w;
  logic [SW-1:0]       sh_amt;
  logic                sh_big;
  logic [bits-1:0]     alu_lo;
  logic                alu_c, alu_v, alu_ill;
  logic [2*bits-1:0]   acc_step;
  logic                is_mul;

  assign sum_w    = {1'b0, RA} + {1'b0, RB};
  assign dif_w    = {1'b0, RA} - {1'b0, RB};
  assign sh_amt   = RB[SW-1:0];
  // Only reachable when bits is not a power of two.
  assign sh_big   = ({1'b0, sh_amt} >= (SW+1)'(bits));
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign is_mul   = (op_e'(op) == OP_MUL);

  // Single-cycle result and flags for every non-MUL opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would infer a latch.
    alu_lo  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        alu_lo = sum_w[bits-1:0];
        alu_c  = sum_w[bits];
        alu_v  = (RA[bits-1] == RB[bits-1]) && (sum_w[bits-1] != RA[bits-1]);
      end
      OP_SUB: begin
        alu_lo = dif_w[bits-1:0];
        alu_c  = dif_w[bits];              // borrow
        alu_v  = (RA[bits-1] != RB[bits-1]) && (dif_w[bits-1] != RA[bits-1]);
      end
      OP_AND: alu_lo = RA & RB;
      OP_OR:  alu_lo = RA | RB;
      OP_XOR: alu_lo = RA ^ RB;
      OP_SHL: alu_lo = sh_big ? '0 : (RA << sh_amt);
      OP_SHR: alu_lo = sh_big ? '0 : (RA >> sh_amt);
      OP_MUL: alu_ill = !MUL_EN;           // result stays 0, so zero=1
      default: alu_lo = '0;
    endcase
  end

  // Next-state logic: accept, multiply iteration, and result handoff.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    ill_d    = ill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mul && MUL_EN) begin
            mcand_d  = {{bits{1'b0}}, RA};
            mplier_d = RB;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            lo_d    = alu_lo;
            hi_d    = '0;
            c_d     = alu_c;
            v_d     = alu_v;
            z_d     = (alu_lo == '0);
            ill_d   = alu_ill;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        if (cnt_q == SW'(bits - 1)) begin
          lo_d    = acc_step[bits-1:0];
          hi_d    = acc_step[2*bits-1:bits];
          c_d     = 1'b0;
          v_d     = 1'b0;
          z_d     = (acc_step == '0);
          ill_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the multiply datapath is reset as well, so a MUL cut short by reset leaves nothing that could surface later.
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge values together.
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
      ill_q    <= ill_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = lo_q;
  assign out_hi    = hi_q;
  assign carry_out = c_q;
  assign overflow  = v_q;
  assign zero      = z_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_a2_seq.sv
// Directed testbench for alu_a2_seq at bits=8, with MUL_EN=1 and MUL_EN=0.
module tb_alu_a2_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0, in_valid0 = 1'b0, out_ready = 1'b1;
  logic [7:0] ra = '0, rb = '0;
  logic [2:0] op = '0;

  logic       in_ready, out_valid, carry_out, overflow, zero, illegal;
  logic [7:0] out, out_hi;
  logic       in_ready0, out_valid0, carry_out0, overflow0, zero0, illegal0;
  logic [7:0] out0, out_hi0;

  // Observed vector: {out_valid, out, out_hi, carry_out, overflow, zero, illegal}
  logic [20:0] obs, obs0;
  assign obs  = {out_valid, out, out_hi, carry_out, overflow, zero, illegal};
  assign obs0 = {out_valid0, out0, out_hi0, carry_out0, overflow0, zero0, illegal0};

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  alu_a2_seq #(.bits(8), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .RA(ra), .RB(rb), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .illegal(illegal)
  );

  alu_a2_seq #(.bits(8), .MUL_EN(1'b0)) u_dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .RA(ra), .RB(rb), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
    .out(out0), .out_hi(out_hi0), .carry_out(carry_out0), .overflow(overflow0),
    .zero(zero0), .illegal(illegal0)
  );

  always #5 clk = ~clk;

  // Present one operation to the main DUT and release in_valid just after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; ra = a; rb = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #1 rst_n = 1'b0; #11;
    total_cnt++;
    if (obs !== 21'h0) $display("FAIL reset_outputs: got %h expected %h", obs, 21'h0);
    else pass_cnt++;
    total_cnt++;
    if ({in_ready, in_ready0, obs0} !== {2'b11, 21'h0})
      $display("FAIL reset_ready: got %b expected %b", {in_ready, in_ready0, obs0}, {2'b11, 21'h0});
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Each row: op, RA, RB, expected observed vector one cycle after accept.
  task automatic test_single_cycle();
    logic [2:0]  t_op [8];
    logic [7:0]  t_a  [8];
    logic [7:0]  t_b  [8];
    logic [20:0] t_e  [8];
    t_op[0] = ADD;  t_a[0] = 8'hFF; t_b[0] = 8'h01; t_e[0] = {1'b1, 8'h00, 8'h00, 4'b1010};
    t_op[1] = SUB;  t_a[1] = 8'h05; t_b[1] = 8'h07; t_e[1] = {1'b1, 8'hFE, 8'h00, 4'b1000};
    t_op[2] = SUB;  t_a[2] = 8'h80; t_b[2] = 8'h01; t_e[2] = {1'b1, 8'h7F, 8'h00, 4'b0100};
    t_op[3] = ADD;  t_a[3] = 8'h7F; t_b[3] = 8'h01; t_e[3] = {1'b1, 8'h80, 8'h00, 4'b0100};
    t_op[4] = SHL;  t_a[4] = 8'h81; t_b[4] = 8'h0B; t_e[4] = {1'b1, 8'h08, 8'h00, 4'b0000};
    t_op[5] = SHR;  t_a[5] = 8'h81; t_b[5] = 8'h07; t_e[5] = {1'b1, 8'h01, 8'h00, 4'b0000};
    t_op[6] = AND_; t_a[6] = 8'hF0; t_b[6] = 8'h3C; t_e[6] = {1'b1, 8'h30, 8'h00, 4'b0000};
    t_op[7] = SUB;  t_a[7] = 8'h33; t_b[7] = 8'h33; t_e[7] = {1'b1, 8'h00, 8'h00, 4'b0010};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      total_cnt++;
      if (obs !== t_e[i]) $display("FAIL single_cycle[%0d]: got %h expected %h", i, obs, t_e[i]);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
        $display("FAIL pulse_end[%0d]: got %b expected 01", i, {out_valid, in_ready});
      else pass_cnt++;
    end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    issue(MUL, 8'hFF, 8'hFF);
    for (int i = 1; i <= 8; i++) begin
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b00)
        $display("FAIL mul_busy[%0d]: got %b expected 00", i, {out_valid, in_ready});
      else pass_cnt++;
      in_valid = i[0];
      op = ADD; ra = 8'(i); rb = 8'h11;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (obs !== {1'b1, 8'h01, 8'hFE, 4'b0000})
      $display("FAIL mul_result: got %h expected %h", obs, {1'b1, 8'h01, 8'hFE, 4'b0000});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(XOR_, 8'hAA, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({in_ready, obs} !== {1'b0, 1'b1, 8'h00, 8'h00, 4'b0010})
        $display("FAIL hold[%0d]: got %h expected %h", i, {in_ready, obs}, {1'b0, 1'b1, 8'h00, 8'h00, 4'b0010});
      else pass_cnt++;
      if (i == 4) out_ready = 1'b1;
      @(posedge clk); #1;
    end
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL hold_release: got %b expected 01", {out_valid, in_ready});
    else pass_cnt++;
  endtask

  // in_valid stays high across DONE; the second op must be taken only once back in IDLE.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    op = AND_; ra = 8'hC3; rb = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    op = OR_; ra = 8'hF0; rb = 8'h0C;
    total_cnt++;
    if (obs !== {1'b1, 8'h03, 8'h00, 4'b0000})
      $display("FAIL b2b_first: got %h expected %h", obs, {1'b1, 8'h03, 8'h00, 4'b0000});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL b2b_gap: got %b expected 01", {out_valid, in_ready});
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if (obs !== {1'b1, 8'hFC, 8'h00, 4'b0000})
      $display("FAIL b2b_second: got %h expected %h", obs, {1'b1, 8'hFC, 8'h00, 4'b0000});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    issue(MUL, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, obs} !== {1'b1, 21'h0})
      $display("FAIL reset_mid_mul: got %h expected %h", {in_ready, obs}, {1'b1, 21'h0});
    else pass_cnt++;
    op = ADD; ra = 8'h02; rb = 8'h03; in_valid = 1'b1;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if (obs !== {1'b1, 8'h05, 8'h00, 4'b0000})
      $display("FAIL after_reset_add: got %h expected %h", obs, {1'b1, 8'h05, 8'h00, 4'b0000});
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
        $display("FAIL no_stale[%0d]: got %b expected 01", i, {out_valid, in_ready});
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    op = MUL; ra = 8'h03; rb = 8'h05; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    total_cnt++;
    if (obs0 !== {1'b1, 8'h00, 8'h00, 4'b0011})
      $display("FAIL illegal_mul: got %h expected %h", obs0, {1'b1, 8'h00, 8'h00, 4'b0011});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({out_valid0, in_ready0} !== 2'b01)
      $display("FAIL illegal_end: got %b expected 01", {out_valid0, in_ready0});
    else pass_cnt++;
    op = ADD; ra = 8'h10; rb = 8'h20; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    total_cnt++;
    if (obs0 !== {1'b1, 8'h30, 8'h00, 4'b0000})
      $display("FAIL nomul_add: got %h expected %h", obs0, {1'b1, 8'h30, 8'h00, 4'b0000});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_a2_seq.md
Name: alu_a2_seq

Overview:
Parametrised, registered successor to the single-cycle add/sub ALU. It extends the operation set to logic, shift and iterative multiply, and adds status flags. Operands are taken and results returned through valid/ready handshakes, so the block can sit between a register-file read stage and a writeback stage with back-pressure. One operation is in flight at a time.

Parameters:
bits, 8, operand/result width; legal range 2..32.
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as an illegal opcode.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and opcode valid
in_ready  out  1  block can accept an operation
RA  in  bits  operand A
RB  in  bits  operand B
op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out  out  bits  result low word
out_hi  out  bits  MUL high word; 0 for all other ops
carry_out  out  1  ADD: carry; SUB: borrow (1 when RA < RB unsigned); else 0
overflow  out  1  ADD/SUB signed overflow; else 0
zero  out  1  1 when out == 0 (MUL: when {out_hi,out} == 0)
illegal  out  1  op was MUL with MUL_EN=0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1. out_valid, out, out_hi, carry_out, overflow, zero and illegal are all 0. Any in-flight MUL is discarded, with no result produced.
- Acceptance: an operation is accepted on a rising edge where in_valid && in_ready. RA, RB and op are captured, so inputs may change afterwards.
- in_ready = 1 only in IDLE. It is registered, not combinational from out_ready.
- States:
  - IDLE: on accept of a non-MUL op, compute and go to DONE. On accept of MUL with MUL_EN=1, go to MUL.
  - MUL: shift-add over bits cycles, one multiplier bit per cycle, LSB first. After the bits-th iteration, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency from accept edge N:
  - Non-MUL: out_valid rises after edge N (visible in cycle N+1).
  - MUL: out_valid visible in cycle N+bits+1.
  - Minimum issue interval is 2 cycles: accept, then DONE with out_ready=1, then IDLE.
- Hold: while out_valid=1 && out_ready=0, out, out_hi and all flags are held stable. Results are never dropped or overwritten.
- Arithmetic:
  - ADD/SUB use a bits+1-wide intermediate. carry_out is bit [bits] of that intermediate (for SUB this is the borrow).
  - ADD overflow: operand signs equal and result sign differs.
  - SUB overflow: operand signs differ and result sign differs from RA.
- Shifts: amount is RB modulo 2^clog2(bits). An amount >= bits (possible only for non-power-of-2 bits) gives 0. SHR fills with 0.
- MUL: unsigned full product. {out_hi,out} = RA*RB (2*bits wide); carry_out=0, overflow=0.
- Illegal opcode (MUL with MUL_EN=0): go directly to DONE with out=0, out_hi=0, zero=1, illegal=1, same latency as a non-MUL op.
- in_valid held high while in_ready=0 has no effect and does not stall or corrupt the in-flight op.
- Reset asserted mid-MUL or in DONE: all outputs are 0 immediately (asynchronous). After rst_n release, the first accept is possible on the first rising edge.

Test Plan:
- bits=8, ADD RA=0xFF RB=0x01, out_ready=1 -> cycle N+1: out=0x00, carry_out=1, zero=1, overflow=0, out_valid pulses 1 cycle.
- SUB RA=0x05 RB=0x07 -> out=0xFE, carry_out=1, overflow=0. Then SUB RA=0x80 RB=0x01 -> out=0x7F, carry_out=0, overflow=1.
- ADD RA=0x7F RB=0x01 -> out=0x80, overflow=1. SHL RA=0x81 RB=0x0B -> out=0x08 (amount 3). SHR RA=0x81 RB=0x07 -> out=0x01.
- MUL RA=0xFF RB=0xFF accepted at edge N -> out_valid first high in cycle N+9 with out_hi=0xFE, out=0x01, zero=0. in_ready=0 throughout, and in_valid toggling during MUL is ignored.
- Back-pressure: XOR RA=0xAA RB=0xAA with out_ready=0 for 5 cycles -> out=0x00, zero=1 stable for all 5 cycles. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Reset mid-MUL, 4 cycles after accept -> all outputs 0 immediately. After release, ADD 0x02+0x03 gives out=0x05 one cycle after accept, with no stale MUL result appearing. Repeat with MUL_EN=0 and op=111 -> illegal=1, out=0, zero=1.
